// File: rtl/fir_atl_pkg.sv
// Shared types and default widths for the FirCM Atlantic receive endpoint.
// The entry struct describes one buffered sample at the default output width.
package fir_atl_pkg;

    localparam int DEF_IN_WIDTH  = 24;
    localparam int DEF_OUT_WIDTH = 16;

    typedef enum logic {
        IDLE,
        IN_PKT
    } frame_state_t;

    typedef struct packed {
        logic                     sop;
        logic                     eop;
        logic [DEF_OUT_WIDTH-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/fir_sink_fifo.sv
// Synchronous FIFO with a registered first-word-fall-through output stage.
// fill counts every stored word, including the one held in the output register.
module fir_sink_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_data,
    output logic [AW:0]      fill
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             take;
    logic             load;

    // The output register refills whenever it is empty or being consumed.
    assign take = out_vld && pop;
    assign load = (!out_vld || take) && (cnt != '0);
    assign fill = cnt + (AW+1)'(out_vld);

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            out_vld  <= 1'b0;
            out_data <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (load) begin
                rd_ptr   <= rd_ptr + AW'(1);
                out_data <= mem[rd_ptr];
                out_vld  <= 1'b1;
            end else if (take) begin
                out_vld  <= 1'b0;
            end
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(load);
        end
    end

    // NOTE: storage has no reset; pointers and count alone define which words are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && fill == (AW+1)'(DEPTH)));
        end
    end

endmodule

// File: rtl/fir_atlantic_sink.sv
// Atlantic receive endpoint: rescales FIR results, buffers them, drives ena_o back-pressure.
// Define FIR_SINK_FRAME_CHECK_EN to enable the framing FSM, err_o and err_cnt.
module fir_atlantic_sink
    import fir_atl_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int SHIFT     = 8,
    parameter int PKT_LEN   = 16,
    parameter int DEPTH     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dav_o,
    output logic                 ena_o,
    input  logic                 sop_o,
    input  logic                 eop_o,
    input  logic [IN_WIDTH-1:0]  dat_o,
    output logic [OUT_WIDTH-1:0] smp_data,
    output logic                 smp_sop,
    output logic                 smp_eop,
    output logic                 smp_vld,
    input  logic                 smp_rdy,
    output logic                 err_o,
    output logic [7:0]           err_cnt
);

    localparam int FW = $clog2(DEPTH) + 1;
    localparam int RND_BIT = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [IN_WIDTH:0] RND =
        (SHIFT > 0) ? ((IN_WIDTH+1)'(1) << RND_BIT) : '0;
    localparam logic signed [IN_WIDTH:0] SAT_MAX = (IN_WIDTH+1)'(2**(OUT_WIDTH-1) - 1);
    localparam logic signed [IN_WIDTH:0] SAT_MIN = ~SAT_MAX;

    logic                       beat;
    logic                       keep;
    logic                       push;
    logic                       pop_fire;
    logic [FW-1:0]              fill;
    logic [FW-1:0]              fill_next;
    logic signed [IN_WIDTH:0]   rnd_sum;
    logic signed [IN_WIDTH:0]   shifted;
    logic [OUT_WIDTH-1:0]       sample;
    logic [OUT_WIDTH+1:0]       out_word;

    // One guard bit keeps the rounding carry from wrapping.
    // NOTE: always_comb assigns every output before any branch, so no latch is inferred.
    always_comb begin
        rnd_sum = $signed({dat_o[IN_WIDTH-1], dat_o}) + RND;
        shifted = rnd_sum >>> SHIFT;
        sample  = shifted[OUT_WIDTH-1:0];
        if (shifted > SAT_MAX)      sample = SAT_MAX[OUT_WIDTH-1:0];
        else if (shifted < SAT_MIN) sample = SAT_MIN[OUT_WIDTH-1:0];
    end

    assign beat      = ena_o;
    assign push      = beat && keep;
    assign pop_fire  = smp_vld && smp_rdy;
    assign fill_next = fill + FW'(push) - FW'(pop_fire);

    // Two free slots cover the beat that lands while ena_o is still registered high.
    always_ff @(posedge clk) begin
        if (rst) ena_o <= 1'b0;
        else     ena_o <= dav_o && (fill_next <= FW'(DEPTH - 3));
    end

`ifdef FIR_SINK_FRAME_CHECK_EN
    localparam int CW = $clog2(PKT_LEN + 1);

    frame_state_t  state;
    frame_state_t  state_next;
    logic [CW-1:0] beat_cnt;
    logic [CW-1:0] cnt_next;
    logic [CW-1:0] pos;
    logic          frame_err;

    // Position of the current beat; a sop always restarts the count.
    assign pos = sop_o ? CW'(1) : beat_cnt + CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            beat_cnt <= '0;
        end else if (beat) begin
            state    <= state_next;
            beat_cnt <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = beat_cnt;
        if (state == IDLE && !sop_o) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else if (eop_o || pos == CW'(PKT_LEN)) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            state_next = IN_PKT;
            cnt_next   = pos;
        end
    end

    always_comb begin
        keep      = (state == IN_PKT) || sop_o;
        frame_err = !keep
                 || (state == IN_PKT && sop_o)
                 || (eop_o != (pos == CW'(PKT_LEN)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_o   <= 1'b0;
            err_cnt <= '0;
        end else begin
            err_o <= beat && frame_err;
            if (beat && frame_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    assign keep    = 1'b1;
    assign err_o   = 1'b0;
    assign err_cnt = '0;
`endif

    fir_sink_fifo #(
        .WIDTH (OUT_WIDTH + 2),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({sop_o, eop_o, sample}),
        .pop       (smp_rdy),
        .out_vld   (smp_vld),
        .out_data  (out_word),
        .fill      (fill)
    );

    assign {smp_sop, smp_eop, smp_data} = out_word;

endmodule

// File: tb/tb_fir_atlantic_sink.sv
// Self-checking bench for fir_atlantic_sink against a queue-based behavioural model.
// Framing expectations follow FIR_SINK_FRAME_CHECK_EN when it is defined for the build.
module tb_fir_atlantic_sink;
    import fir_atl_pkg::*;

    localparam int IW      = 24;
    localparam int OW      = 16;
    localparam int SHIFT   = 8;
    localparam int PKT_LEN = 16;
    localparam int DEPTH   = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          dav_o = 1'b0;
    logic          ena_o;
    logic          sop_o = 1'b0;
    logic          eop_o = 1'b0;
    logic [IW-1:0] dat_o = '0;
    logic [OW-1:0] smp_data;
    logic          smp_sop;
    logic          smp_eop;
    logic          smp_vld;
    logic          smp_rdy = 1'b0;
    logic          err_o;
    logic [7:0]    err_cnt;

    always #5 clk = ~clk;

    fir_atlantic_sink #(
        .IN_WIDTH (IW), .OUT_WIDTH (OW), .SHIFT (SHIFT), .PKT_LEN (PKT_LEN), .DEPTH (DEPTH)
    ) dut (
        .clk (clk), .rst (rst), .dav_o (dav_o), .ena_o (ena_o),
        .sop_o (sop_o), .eop_o (eop_o), .dat_o (dat_o),
        .smp_data (smp_data), .smp_sop (smp_sop), .smp_eop (smp_eop),
        .smp_vld (smp_vld), .smp_rdy (smp_rdy), .err_o (err_o), .err_cnt (err_cnt)
    );

    typedef struct packed {
        logic          sop;
        logic          eop;
        logic [IW-1:0] dat;
    } beat_t;

    typedef struct {
        fifo_entry_t e;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    fifo_entry_t got[$];
    beat_t       pkt[$];
    logic [7:0]  cnt_after[$];
    logic        err_after[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pos = 0;
    int exp_cnt = 0;
    int stall_ena = 0;
    bit exp_ena = 1'b0;
    bit exp_err = 1'b0;
    bit in_pkt = 1'b0;
    bit took;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [OW-1:0] rescale(input logic [IW-1:0] d);
        longint x;
        x = longint'($signed(d));
        if (SHIFT > 0) x = x + (longint'(1) << (SHIFT - 1));
        x = x >>> SHIFT;
        if (x > longint'(2**(OW-1) - 1))   x = longint'(2**(OW-1) - 1);
        else if (x < -longint'(2**(OW-1))) x = -longint'(2**(OW-1));
        return x[OW-1:0];
    endfunction

    task automatic model_beat(input logic sop, input logic eop, input logic [IW-1:0] d);
        bit   kept = 1'b1;
        exp_t ent;
`ifdef FIR_SINK_FRAME_CHECK_EN
        bit err = 1'b0;
        if (sop) begin
            err    = in_pkt;
            in_pkt = 1'b1;
            pos    = 1;
        end else if (!in_pkt) begin
            err  = 1'b1;
            kept = 1'b0;
        end else begin
            pos++;
        end
        if (kept && (eop || pos == PKT_LEN)) begin
            if (!(eop && pos == PKT_LEN)) err = 1'b1;
            in_pkt = 1'b0;
        end
        exp_err = err;
        if (err && exp_cnt < 255) exp_cnt++;
`endif
        if (kept) begin
            ent.e.sop  = sop;
            ent.e.eop  = eop;
            ent.e.data = rescale(d);
            ent.cyc    = cyc;
            q.push_back(ent);
        end
    endtask

    // One clock edge: advance the model on pre-edge values, then compare just after the edge.
    task automatic tick(output bit beat);
        bit            pre_rst = rst;
        bit            pre_vld = (q.size() > 0) && (q[0].cyc < cyc);
        bit            popd    = pre_vld && smp_rdy;
        logic          b_sop   = sop_o;
        logic          b_eop   = eop_o;
        logic [IW-1:0] b_dat   = dat_o;
        bit            vld;
        fifo_entry_t   obs;
        beat = exp_ena && !pre_rst;
        if (popd) begin
            obs.sop  = smp_sop;
            obs.eop  = smp_eop;
            obs.data = smp_data;
            got.push_back(obs);
        end
        @(posedge clk);
        cyc++;
        exp_err = 1'b0;
        if (pre_rst) begin
            q.delete();
            in_pkt  = 1'b0;
            pos     = 0;
            exp_ena = 1'b0;
            exp_cnt = 0;
        end else begin
            if (popd) void'(q.pop_front());
            if (beat) model_beat(b_sop, b_eop, b_dat);
            exp_ena = dav_o && (q.size() <= DEPTH - 3);
        end
        #1;
        vld = (q.size() > 0) && (q[0].cyc < cyc);
        check("ena_o", ena_o, exp_ena);
        check("smp_vld", smp_vld, vld);
        if (vld) begin
            check("smp_data", smp_data, q[0].e.data);
            check("smp_sop", smp_sop, q[0].e.sop);
            check("smp_eop", smp_eop, q[0].e.eop);
        end else if (pre_rst) begin
            check("rst_smp_data", smp_data, 0);
            check("rst_smp_sop", smp_sop, 0);
            check("rst_smp_eop", smp_eop, 0);
        end
        check("err_o", err_o, exp_err);
        check("err_cnt", err_cnt, exp_cnt);
    endtask

    // Present pkt beat by beat; mode 2 randomises dav_o and smp_rdy, stall holds smp_rdy low.
    task automatic run_beats(input int mode, input int stall);
        int i = 0;
        int n = 0;
        bit b;
        stall_ena = 0;
        while (i < pkt.size() && n < 400) begin
            sop_o = pkt[i].sop;
            eop_o = pkt[i].eop;
            dat_o = pkt[i].dat;
            if (i == pkt.size() - 1 && ena_o) dav_o = 1'b0;
            else if (mode == 2)               dav_o = ($urandom_range(3) != 0);
            else                              dav_o = 1'b1;
            if (n < stall)      smp_rdy = 1'b0;
            else if (mode == 2) smp_rdy = 1'($urandom_range(1));
            else                smp_rdy = 1'b1;
            tick(b);
            if (n < stall && ena_o) stall_ena++;
            if (b) begin
                cnt_after.push_back(err_cnt);
                err_after.push_back(err_o);
                i++;
            end
            n++;
        end
        check("beats_taken", i, pkt.size());
        dav_o = 1'b0;
        sop_o = 1'b0;
        eop_o = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        bit b;
        dav_o   = 1'b0;
        smp_rdy = 1'b1;
        while ((q.size() > 0 || exp_ena) && n < 100) begin
            tick(b);
            n++;
        end
        check("drain_empty", q.size(), 0);
    endtask

    task automatic build(input int n, input int eop_at, input bit with_sop, input bit rnd);
        beat_t bt;
        pkt.delete();
        for (int k = 0; k < n; k++) begin
            bt.sop = with_sop && (k == 0);
            bt.eop = (k == eop_at);
            bt.dat = rnd ? IW'($urandom) : IW'(256 * k);
            pkt.push_back(bt);
        end
    endtask

    initial begin
        // Reset state
        tick(took);
        tick(took);
        rst = 1'b0;
        tick(took);

        // Nominal packet
        got.delete();
        build(PKT_LEN, PKT_LEN - 1, 1'b1, 1'b0);
        run_beats(1, 0);
        drain();
        check("nom_count", got.size(), PKT_LEN);
        for (int k = 0; k < PKT_LEN; k++) begin
            check("nom_data", got[k].data, 32'(k));
            check("nom_sop", got[k].sop, 32'(k == 0));
            check("nom_eop", got[k].eop, 32'(k == PKT_LEN - 1));
        end
        check("nom_err_cnt", err_cnt, 0);

        // Rounding and saturation
        got.delete();
        build(PKT_LEN, PKT_LEN - 1, 1'b1, 1'b1);
        pkt[0].dat = 24'h000180;
        pkt[1].dat = 24'hFFFE80;
        pkt[2].dat = 24'h7FFFFF;
        pkt[3].dat = 24'h800000;
        run_beats(1, 0);
        drain();
        check("rnd_pos", got[0].data, 32'h0002);
        check("rnd_neg", got[1].data, 32'hFFFF);
        check("sat_max", got[2].data, 32'h7FFF);
        check("sat_min", got[3].data, 32'h8000);

        // Back-pressure: smp_rdy low for 20 cycles with dav_o high
        got.delete();
        build(PKT_LEN, PKT_LEN - 1, 1'b1, 1'b1);
        run_beats(1, 20);
        check("bp_ena_cycles", stall_ena, 6);
        drain();
        check("bp_count", got.size(), PKT_LEN);

        // Randomised traffic with random dav_o gaps and smp_rdy stalls
        for (int p = 0; p < 4; p++) begin
            build(PKT_LEN, PKT_LEN - 1, 1'b1, 1'b1);
            run_beats(2, 0);
        end
        drain();

        // Framing errors: early eop, then a packet with no sop
        got.delete();
        cnt_after.delete();
        err_after.delete();
        build(10, 9, 1'b1, 1'b1);
        run_beats(1, 0);
        build(PKT_LEN, PKT_LEN - 1, 1'b0, 1'b1);
        run_beats(1, 0);
        drain();
`ifdef FIR_SINK_FRAME_CHECK_EN
        check("early_eop_no_err_before", err_after[8], 0);
        check("early_eop_err_o", err_after[9], 1);
        check("early_eop_cnt", cnt_after[9], 1);
        check("no_sop_cnt", cnt_after[10], 2);
        check("frame_kept", got.size(), 10);
`else
        check("early_eop_cnt", cnt_after[9], 0);
        check("no_sop_cnt", cnt_after[10], 0);
        check("frame_kept", got.size(), 10 + PKT_LEN);
`endif

        // Reset at beat 7, then a clean packet
        build(7, -1, 1'b1, 1'b1);
        run_beats(1, 0);
        rst = 1'b1;
        tick(took);
        rst = 1'b0;
        got.delete();
        build(PKT_LEN, PKT_LEN - 1, 1'b1, 1'b1);
        run_beats(1, 0);
        drain();
        check("post_rst_count", got.size(), PKT_LEN);
        check("post_rst_err_cnt", err_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
